accumulator_mc: RTL

- Parametrised multi-channel signed accumulator; next generation of the single-channel 32-bit accumulator.
- Keeps NUM_CH independent two's-complement running sums, each ACC_W bits wide, and adds one DATA_W sample per cycle to a selected channel.
- Adds runtime wrap/saturate mode, per-channel sticky overflow, per-channel and global clear, and a registered read port with optional clear-on-read.
- Sits in the arithmetic library as a drop-in statistics/integration engine for DSP and counter datapaths.

---
 rtl/accumulator_pkg.sv | 26 ++
 rtl/accumulator_sat_add.sv | 32 +++
 rtl/accumulator_mc.sv | 127 ++++++++++++
 3 files changed

// File: rtl/accumulator_pkg.sv
// Shared constants and helpers for the multi-channel accumulator.
package accumulator_pkg;

  localparam logic ACC_MODE_WRAP = 1'b0;
  localparam logic ACC_MODE_SAT  = 1'b1;

  // Widest accumulator the clamp helpers can describe.
  localparam int unsigned ACC_MAX_W = 64;

  // Largest positive two's-complement value of width w, zero-extended.
  function automatic logic [ACC_MAX_W-1:0] signed_max(input int unsigned w);
    logic [ACC_MAX_W-1:0] v;
    v = '1;
    v = v >> (ACC_MAX_W - w + 1);
    return v;
  endfunction

  // Most negative two's-complement value of width w, sign-extended.
  function automatic logic [ACC_MAX_W-1:0] signed_min(input int unsigned w);
    logic [ACC_MAX_W-1:0] v;
    v = '1;
    v = v << (w - 1);
    return v;
  endfunction

endpackage

// File: rtl/accumulator_sat_add.sv
// Combinational signed add of a sign-extended sample onto an accumulator,
// with overflow detection and optional saturation.
module accumulator_sat_add
  import accumulator_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 40
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              mode_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  localparam logic [ACC_W-1:0] MAX_V = ACC_W'(signed_max(ACC_W));
  localparam logic [ACC_W-1:0] MIN_V = ACC_W'(signed_min(ACC_W));

  logic [ACC_W:0] sum_full;

  always_comb begin
    sum_full = {acc_i[ACC_W-1], acc_i}
             + {{(ACC_W + 1 - DATA_W){data_i[DATA_W-1]}}, data_i};
    // Result fits in ACC_W signed bits only if the top two bits agree.
    ovf_o = sum_full[ACC_W] ^ sum_full[ACC_W-1];
    sum_o = sum_full[ACC_W-1:0];
    if (ovf_o && (mode_i == ACC_MODE_SAT)) begin
      sum_o = sum_full[ACC_W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/accumulator_mc.sv
// Multi-channel signed accumulator with wrap/saturate, sticky per-channel
// overflow, per-channel/global clear and a registered read port.
module accumulator_mc
  import accumulator_pkg::*;
#(
  parameter  int unsigned DATA_W        = 32,
  parameter  int unsigned ACC_W         = 40,
  parameter  int unsigned NUM_CH        = 4,
  parameter  int unsigned CLEAR_ON_READ = 0,
  localparam int unsigned CH_W          = $clog2(NUM_CH)
) (
  input  logic              i_CLK,
  input  logic              i_RESET,
  input  logic              i_ENABLE,
  input  logic [CH_W-1:0]   i_CH,
  input  logic [DATA_W-1:0] i_DATA_IN,
  input  logic              i_MODE,
  input  logic              i_CLEAR,
  input  logic              i_CLEAR_ALL,
  input  logic              i_RD_REQ,
  input  logic [CH_W-1:0]   i_RD_CH,
  output logic              o_RD_VALID,
  output logic [ACC_W-1:0]  o_RD_DATA,
  output logic              o_RD_OVF,
  output logic [NUM_CH-1:0] o_OVF
);

  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic              rd_valid_q;
  logic [ACC_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_ovf_q, rd_ovf_d;

  logic [31:0]       ch_sel, rd_sel;
  logic              ch_ok, rd_ok, rd_clr;
  logic [ACC_W-1:0]  add_opnd, add_sum;
  logic              add_ovf;

  always_comb begin
    ch_sel   = 32'(i_CH);
    rd_sel   = 32'(i_RD_CH);
    ch_ok    = ch_sel < NUM_CH;
    rd_ok    = rd_sel < NUM_CH;
    rd_clr   = (CLEAR_ON_READ != 0) && i_RD_REQ && rd_ok;
    add_opnd = '0;
    // A clear-on-read of the target channel turns the add into a fresh start.
    if (ch_ok && !(rd_clr && (rd_sel == ch_sel))) begin
      add_opnd = acc_q[i_CH];
    end
  end

  accumulator_sat_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .acc_i  (add_opnd),
    .data_i (i_DATA_IN),
    .mode_i (i_MODE),
    .sum_o  (add_sum),
    .ovf_o  (add_ovf)
  );

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      acc_d[c] = acc_q[c];
      ovf_d[c] = ovf_q[c];
      if (i_CLEAR_ALL) begin
        acc_d[c] = '0;
        ovf_d[c] = 1'b0;
      end else if (i_CLEAR && (ch_sel == c)) begin
        acc_d[c] = '0;
        ovf_d[c] = 1'b0;
      end else if (rd_clr && (rd_sel == c)) begin
        if (i_ENABLE && (ch_sel == c)) begin
          acc_d[c] = add_sum;
          ovf_d[c] = add_ovf;
        end else begin
          acc_d[c] = '0;
          ovf_d[c] = 1'b0;
        end
      end else if (i_ENABLE && (ch_sel == c)) begin
        acc_d[c] = add_sum;
        ovf_d[c] = ovf_q[c] | add_ovf;
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_ovf_d  = rd_ovf_q;
    if (i_RD_REQ) begin
      rd_data_d = '0;
      rd_ovf_d  = 1'b0;
      if (rd_ok) begin
        rd_data_d = acc_q[i_RD_CH];
        rd_ovf_d  = ovf_q[i_RD_CH];
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
      end
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
      end
      ovf_q      <= ovf_d;
      rd_valid_q <= i_RD_REQ;
      rd_data_q  <= rd_data_d;
      rd_ovf_q   <= rd_ovf_d;
    end
  end

  assign o_RD_VALID = rd_valid_q;
  assign o_RD_DATA  = rd_data_q;
  assign o_RD_OVF   = rd_ovf_q;
  assign o_OVF      = ovf_q;

endmodule
